// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared step names, widths and one-hot helper for the CPU control section
package cpu_pkg;

  localparam int STEP_COUNT = 6;

  localparam int STEP1 = 0;
  localparam int STEP2 = 1;
  localparam int STEP3 = 2;
  localparam int STEP4 = 3;
  localparam int STEP5 = 4;
  localparam int STEP6 = 5;

  typedef logic [STEP_COUNT-1:0] step_t;

  // True when exactly one bit is set: nonzero and clearing the lowest set bit leaves zero.
  function automatic logic onehot_ok(input step_t s);
    return (s != '0) && ((s & (s - step_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/clock_stepper.sv
// rtl/clock_stepper.sv - free-running one-hot instruction-cycle stepper with self-recovery
module clock_stepper
  import cpu_pkg::*;
#(
  parameter int NUM_STEPS = STEP_COUNT
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [NUM_STEPS-1:0] step
);

  localparam logic [NUM_STEPS-1:0] FIRST_STEP = {{(NUM_STEPS-1){1'b0}}, 1'b1};

  logic                 legal;
  logic [NUM_STEPS-1:0] next_step;

  // Any illegal pattern (zero, several ones, power-up garbage) reloads step 1 on the next edge.
  always_comb begin
    legal     = (step != '0) && ((step & (step - FIRST_STEP)) == '0);
    next_step = FIRST_STEP;
    if (legal)
      next_step = {step[NUM_STEPS-2:0], step[NUM_STEPS-1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      step <= FIRST_STEP;
    else
      step <= next_step;
  end

endmodule

// File: tb/tb_clock_stepper.sv
// tb/tb_clock_stepper.sv - directed and randomized checks of clock_stepper against a step-index model
`timescale 1ns/100ps
module tb_clock_stepper;

  localparam int N = 6;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] step;
  bit           run = 1'b0;

  int errors = 0;
  int checks = 0;
  int edges  = 0;
  int idx    = 0;
  int highs [N];

  clock_stepper #(.NUM_STEPS(N)) dut (
    .clk   (clk),
    .reset (reset),
    .step  (step)
  );

  always begin
    #1;
    if (run) clk = ~clk;
  end

  always @(posedge clk) edges++;

  function automatic logic [N-1:0] model_step(input int i);
    logic [N-1:0] one;
    one = 1;
    return one << i;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One rising edge, then sample on the falling edge and compare with the model.
  task automatic tick(input string tag);
    @(posedge clk);
    idx = (idx + 1) % N;
    @(negedge clk);
    check(tag, 32'(step), 32'(model_step(idx)));
    check({tag, "_onehot"}, 32'($onehot(step)), 32'd1);
  endtask

  task automatic reset_pulse(input string tag);
    #0.3 reset = 1'b1;
    #0.2 check({tag, "_async"}, 32'(step), 32'(model_step(0)));
    #0.2 reset = 1'b0;
    idx = 0;
  endtask

  initial begin
    // Reset with the clock idle.
    reset = 1'b0;
    #0.1 reset = 1'b1;
    #0.5 check("reset_idle", 32'(step), 32'(model_step(0)));
    check("reset_no_edge", 32'(edges), 32'd0);
    #1 reset = 1'b0;
    #1 check("release_hold", 32'(step), 32'(model_step(0)));
    idx = 0;
    run = 1'b1;

    // Free run across two wraps.
    for (int i = 0; i < 13; i++) tick("freerun");

    // Walk to the last step and check the wrap.
    while (idx != N - 1) tick("to_last");
    check("at_last", 32'(step), 32'(6'b100000));
    tick("wrap");
    check("wrap_first", 32'(step), 32'(6'b000001));

    // Async reset mid-cycle at step 4.
    while (idx != 3) tick("to_step4");
    check("at_step4", 32'(step), 32'(6'b001000));
    reset_pulse("midcycle");
    tick("after_mid_reset");
    check("after_mid_step2", 32'(step), 32'(6'b000010));

    // Recovery from illegal register contents.
    force dut.step = 6'b000000;
    #0.3 release dut.step;
    idx = N - 1;
    tick("recover_zero");
    tick("recover_zero_next");
    force dut.step = 6'b101000;
    #0.3 release dut.step;
    idx = N - 1;
    tick("recover_multi");
    tick("recover_multi_next");

    // Randomized run with occasional async reset pulses.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) reset_pulse("rand_reset");
      tick("rand_run");
    end

    // Duty: 24 samples at 2 ns period give each bit exactly 4 high periods.
    for (int b = 0; b < N; b++) highs[b] = 0;
    for (int i = 0; i < 24; i++) begin
      tick("duty_run");
      for (int b = 0; b < N; b++) if (step[b] === 1'b1) highs[b]++;
    end
    for (int b = 0; b < N; b++) check($sformatf("duty_bit%0d", b), 32'(highs[b]), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout: observed=no finish expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
